// File: rtl/entity_bus_bridge_pkg.sv
// Shared types and register map for the entity bus bridge.
// Optional feature macro: ENTITY_IRQ_EN (deactivation flags and irq).
package entity_bridge_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  localparam logic REG_POS    = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int X_LSB       = 0;
  localparam int Y_LSB       = 16;
  localparam int ACTIVE_BIT  = 31;
  localparam int FLAG_LSB    = 8;
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/entity_bus_bridge_if.sv
// Avalon-MM slave bundle between NIOS and the entity bus bridge.
// Handshake: read/write are accepted in the cycle presented (no waitrequest);
// readdatavalid pulses once, exactly one cycle after an accepted read; a cycle
// with both read and write performs only the write and returns no data.
interface entity_bus_bridge_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/entity_slot.sv
// One entity's frame-coherent shadow state; enemy slots also hold the
// direction command and (with ENTITY_IRQ_EN) the sticky deactivation flag.
module entity_slot
  import entity_bridge_pkg::*;
#(
  parameter int COORD_W  = 10,
  parameter bit IS_ENEMY = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_sync,
  input  logic [COORD_W-1:0] live_x,
  input  logic [COORD_W-1:0] live_y,
  input  logic               live_active,
  input  logic               dir_we,
  input  dir_t               dir_wdata,
  input  logic               flag_clr,
  output logic [COORD_W-1:0] shadow_x,
  output logic [COORD_W-1:0] shadow_y,
  output logic               shadow_active,
  output dir_t               dir,
  output logic               flag
);

  // The player always reads active, from reset onwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_x      <= '0;
      shadow_y      <= '0;
      shadow_active <= !IS_ENEMY;
    end else if (frame_sync) begin
      shadow_x      <= live_x;
      shadow_y      <= live_y;
      shadow_active <= live_active | !IS_ENEMY;
    end
  end

  if (IS_ENEMY) begin : g_enemy
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    dir <= UP;
      else if (dir_we) dir <= dir_wdata;
    end

`ifdef ENTITY_IRQ_EN
    // A deactivation seen at the snapshot beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                        flag <= 1'b0;
      else if (frame_sync && shadow_active && !live_active) flag <= 1'b1;
      else if (flag_clr)                                   flag <= 1'b0;
    end
`else
    logic unused_clr;
    assign unused_clr = flag_clr;
    assign flag       = 1'b0;
`endif
  end else begin : g_player
    logic unused_ctrl;
    assign unused_ctrl = ^{dir_we, dir_wdata, flag_clr};
    assign dir         = UP;
    assign flag        = 1'b0;
  end

endmodule

// File: rtl/entity_bus_bridge.sv
// NIOS register bridge: frame-coherent entity snapshots, enemy direction
// commands and a one-cycle-latency Avalon read path. Optional: ENTITY_IRQ_EN.
module entity_bus_bridge
  import entity_bridge_pkg::*;
#(
  parameter int NUM_ENEMIES = 5,
  parameter int COORD_W     = 10
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                frame_sync,
  input  logic [NUM_ENEMIES:0][COORD_W-1:0]   ent_x,
  input  logic [NUM_ENEMIES:0][COORD_W-1:0]   ent_y,
  input  logic [NUM_ENEMIES:0]                ent_active,
  entity_bus_bridge_if.slave                  bus,
  output logic [NUM_ENEMIES-1:0][1:0]         enemy_dir
`ifdef ENTITY_IRQ_EN
  ,
  output logic                                irq
`endif
);

  localparam int ADDR_W = $clog2(NUM_ENEMIES + 1) + 1;

  logic [ADDR_W-2:0] idx;
  logic              reg_sel;
  logic              rd_acc;
  logic              wr_pos;
  logic              wr_status;
  logic [31:0]       rd_word;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  logic [COORD_W-1:0]          sh_x   [NUM_ENEMIES+1];
  logic [COORD_W-1:0]          sh_y   [NUM_ENEMIES+1];
  logic [NUM_ENEMIES:0]        sh_act;
  logic [NUM_ENEMIES:0][1:0]   slot_dir;
  logic [NUM_ENEMIES:0]        slot_flag;

  assign idx       = bus.address[ADDR_W-1:1];
  assign reg_sel   = bus.address[0];
  assign rd_acc    = bus.read && !bus.write;
  assign wr_pos    = bus.write && (reg_sel == REG_POS);
  assign wr_status = bus.write && (reg_sel == REG_STATUS) && (idx == '0);

  for (genvar i = 0; i <= NUM_ENEMIES; i++) begin : g_slot
    logic dir_we;
    logic flag_clr;
    if (i == 0) begin : g_player_ctl
      assign dir_we   = 1'b0;
      assign flag_clr = 1'b0;
    end else begin : g_enemy_ctl
      assign dir_we       = wr_pos && (idx == (ADDR_W-1)'(i));
      assign flag_clr     = wr_status && bus.writedata[FLAG_LSB+i-1];
      assign enemy_dir[i-1] = slot_dir[i];
    end

    entity_slot #(
      .COORD_W  (COORD_W),
      .IS_ENEMY (i != 0)
    ) u_slot (
      .clk           (clk),
      .reset_n       (reset_n),
      .frame_sync    (frame_sync),
      .live_x        (ent_x[i]),
      .live_y        (ent_y[i]),
      .live_active   (ent_active[i]),
      .dir_we        (dir_we),
      .dir_wdata     (dir_t'(bus.writedata[1:0])),
      .flag_clr      (flag_clr),
      .shadow_x      (sh_x[i]),
      .shadow_y      (sh_y[i]),
      .shadow_active (sh_act[i]),
      .dir           (slot_dir[i]),
      .flag          (slot_flag[i])
    );
  end

  // Read mux sees pre-edge shadows, so a read alongside frame_sync gets the old frame.
  always_comb begin
    rd_word = '0;
    if (reg_sel == REG_POS) begin
      for (int i = 0; i <= NUM_ENEMIES; i++) begin
        if (idx == (ADDR_W-1)'(i)) begin
          rd_word[X_LSB +: COORD_W] = sh_x[i];
          rd_word[Y_LSB +: COORD_W] = sh_y[i];
          rd_word[ACTIVE_BIT]       = sh_act[i];
        end
      end
    end else if (idx == '0) begin
      rd_word[FRAME_CNT_W-1:0] = frame_cnt;
`ifdef ENTITY_IRQ_EN
      rd_word[FLAG_LSB +: NUM_ENEMIES] = slot_flag[NUM_ENEMIES:1];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
      frame_cnt         <= '0;
    end else begin
      bus.readdatavalid <= rd_acc;
      if (rd_acc)     bus.readdata <= rd_word;
      if (frame_sync) frame_cnt    <= frame_cnt + 1'b1;
    end
  end

`ifdef ENTITY_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |slot_flag[NUM_ENEMIES:1];
  end

  logic unused_misc;
  assign unused_misc = ^{bus.writedata, slot_dir[0], slot_flag[0]};
`else
  logic unused_misc;
  assign unused_misc = ^{bus.writedata, slot_dir[0], slot_flag};
`endif

endmodule

// File: tb/tb_entity_bus_bridge.sv
// Self-checking bench for entity_bus_bridge (default build; ENTITY_IRQ_EN adds irq tests).
module tb_entity_bus_bridge;
  import entity_bridge_pkg::*;

  localparam int N  = 5;
  localparam int CW = 10;
  localparam int AW = 4;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    frame_sync = 1'b0;
  logic [N:0][CW-1:0]      ent_x;
  logic [N:0][CW-1:0]      ent_y;
  logic [N:0]              ent_active;
  logic [N-1:0][1:0]       enemy_dir;
`ifdef ENTITY_IRQ_EN
  logic                    irq;
`endif

  entity_bus_bridge_if #(.ADDR_W(AW)) bus ();

  entity_bus_bridge #(
    .NUM_ENEMIES (N),
    .COORD_W     (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_sync (frame_sync),
    .ent_x      (ent_x),
    .ent_y      (ent_y),
    .ent_active (ent_active),
    .bus        (bus),
    .enemy_dir  (enemy_dir)
`ifdef ENTITY_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int valid_cnt = 0;
  logic [31:0] exp_q[$];

  // Reference model
  logic [CW-1:0] m_x   [0:N];
  logic [CW-1:0] m_y   [0:N];
  logic          m_act [0:N];
  logic [1:0]    m_dir [0:N-1];
  logic [7:0]    m_frame;
  logic [N-1:0]  m_flags;

  function automatic logic [31:0] exp_word(input int idx, input bit sel);
    logic [31:0] w;
    w = '0;
    if (!sel) begin
      if (idx <= N) begin
        w[CW-1:0]  = m_x[idx];
        w[16+:CW]  = m_y[idx];
        w[31]      = (idx == 0) ? 1'b1 : m_act[idx];
      end
    end else if (idx == 0) begin
      w[7:0] = m_frame;
`ifdef ENTITY_IRQ_EN
      w[8+:N] = m_flags;
`endif
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= N; i++) begin
      m_x[i] = '0; m_y[i] = '0; m_act[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) m_dir[i] = 2'd0;
    m_frame = '0;
    m_flags = '0;
  endtask

  task automatic snapshot_model();
`ifdef ENTITY_IRQ_EN
    for (int i = 1; i <= N; i++)
      if (m_act[i] && !ent_active[i]) m_flags[i-1] = 1'b1;
`endif
    for (int i = 0; i <= N; i++) begin
      m_x[i] = ent_x[i]; m_y[i] = ent_y[i]; m_act[i] = ent_active[i];
    end
    m_frame = m_frame + 8'd1;
  endtask

  // Scoreboard: every readdatavalid pops one expected word.
  always @(posedge clk) begin
    #1;
    if (bus.readdatavalid) begin
      logic [31:0] exp;
      valid_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_readdatavalid: got readdata %h, expected no valid", bus.readdata);
      end else begin
        exp = exp_q.pop_front();
        if (bus.readdata !== exp) begin
          n_fail++;
          $display("FAIL readdata: got %h expected %h", bus.readdata, exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic drive_read(input int idx, input bit sel);
    bus.address = {3'(idx), sel};
    bus.read    = 1'b1;
    exp_q.push_back(exp_word(idx, sel));
  endtask

  task automatic do_read(input int idx, input bit sel);
    @(negedge clk);
    drive_read(idx, sel);
    @(negedge clk);
    bus.read = 1'b0;
  endtask

  task automatic do_write(input int idx, input bit sel, input logic [31:0] data);
    @(negedge clk);
    bus.address   = {3'(idx), sel};
    bus.writedata = data;
    bus.write     = 1'b1;
    if (!sel && idx >= 1 && idx <= N) m_dir[idx-1] = data[1:0];
`ifdef ENTITY_IRQ_EN
    if (sel && idx == 0) m_flags = m_flags & ~data[8+:N];
`endif
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_sync = 1'b1;
    snapshot_model();
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    int v;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_read_outputs: got valid %b data %h, expected 0 and 0", bus.readdatavalid, bus.readdata);
    end
    n_checks++;
    if (enemy_dir !== '0) begin
      n_fail++;
      $display("FAIL reset_enemy_dir: got %h expected 0", enemy_dir);
    end
`ifdef ENTITY_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
`endif
    reset_n = 1'b1;
    v = valid_cnt;
    do_read(0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (valid_cnt !== v + 1) begin
      n_fail++;
      $display("FAIL reset_read_valid_count: got %0d expected %0d", valid_cnt - v, 1);
    end
    do_read(0, 1'b1);
  endtask

  task automatic test_snapshot();
    ent_x[3] = 10'h155; ent_y[3] = 10'h0AA; ent_active[3] = 1'b1;
    pulse_frame();
    do_read(3, 1'b0);
    do_read(0, 1'b1);
    ent_x[3] = 10'h2FF;
    do_read(3, 1'b0);
    // Read coinciding with the snapshot returns the old frame.
    @(negedge clk);
    drive_read(3, 1'b0);
    frame_sync = 1'b1;
    snapshot_model();
    @(negedge clk);
    bus.read   = 1'b0;
    frame_sync = 1'b0;
    do_read(3, 1'b0);
    do_read(0, 1'b1);
  endtask

  task automatic test_dir();
    int v;
    do_write(2, 1'b0, 32'h3);
    n_checks++;
    if (enemy_dir[1] !== 2'd3) begin
      n_fail++;
      $display("FAIL dir_write_enemy2: got %0d expected %0d", enemy_dir[1], 3);
    end
    do_write(0, 1'b0, 32'h2);
    do_write(7, 1'b0, 32'h2);
    do_write(3, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (enemy_dir[i] !== m_dir[i]) begin
        n_fail++;
        $display("FAIL dir_ignored_writes[%0d]: got %0d expected %0d", i, enemy_dir[i], m_dir[i]);
      end
    end
    do_read(7, 1'b0);
    do_read(3, 1'b1);
    // Simultaneous read and write: write wins, no data returned.
    v = valid_cnt;
    @(negedge clk);
    bus.address = {3'd4, 1'b0}; bus.writedata = 32'h1;
    bus.read = 1'b1; bus.write = 1'b1;
    m_dir[3] = 2'd1;
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid_cnt !== v) begin
      n_fail++;
      $display("FAIL rw_collision_valid: got %0d valids expected 0", valid_cnt - v);
    end
    n_checks++;
    if (enemy_dir[3] !== 2'd1) begin
      n_fail++;
      $display("FAIL rw_collision_write: got %0d expected %0d", enemy_dir[3], 1);
    end
  endtask

  task automatic test_frame_wrap();
    @(negedge clk);
    frame_sync = 1'b1;
    for (int i = 0; i < 256; i++) begin
      snapshot_model();
      @(negedge clk);
    end
    frame_sync = 1'b0;
    do_read(0, 1'b1);
    pulse_frame();
    do_read(0, 1'b1);
  endtask

`ifdef ENTITY_IRQ_EN
  task automatic test_irq();
    ent_active[5] = 1'b1;
    pulse_frame();
    ent_active[5] = 1'b0;
    pulse_frame();
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set: got %b expected 1", irq);
    end
    do_read(0, 1'b1);
    ent_active[1] = 1'b1;
    pulse_frame();
    ent_active[1] = 1'b0;
    @(negedge clk);
    bus.address = {3'd0, 1'b1}; bus.writedata = 32'h1000; bus.write = 1'b1;
    frame_sync = 1'b1;
    m_flags = m_flags & ~bus.writedata[8+:N];
    snapshot_model();
    @(negedge clk);
    bus.write = 1'b0; frame_sync = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b1) begin
        n_fail++;
        $display("FAIL irq_hold: got %b expected 1", irq);
      end
    end
    do_read(0, 1'b1);
    do_write(0, 1'b1, 32'h100);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: got %b expected 0", irq);
    end
    do_read(0, 1'b1);
  endtask
`endif

  task automatic test_back_to_back();
    int v;
    for (int i = 0; i <= N; i++) begin
      ent_x[i] = CW'($urandom_range(0, 1023));
      ent_y[i] = CW'($urandom_range(0, 1023));
      ent_active[i] = 1'($urandom_range(0, 1));
    end
    pulse_frame();
    v = valid_cnt;
    for (int i = 0; i <= N + 2; i++) begin
      @(negedge clk);
      drive_read(i, 1'b0);
    end
    @(negedge clk);
    bus.read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid_cnt !== v + N + 3) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d expected %0d", valid_cnt - v, N + 3);
    end
    do_read(0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int v;
    v = valid_cnt;
    @(negedge clk);
    bus.address = {3'd0, 1'b0};
    bus.read = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.readdatavalid !== 1'b0 || valid_cnt !== v) begin
      n_fail++;
      $display("FAIL reset_mid_cancel: got valid %b expected 0", bus.readdatavalid);
    end
    @(negedge clk);
    bus.read = 1'b0;
    reset_n  = 1'b1;
    model_reset();
    n_checks++;
    if (enemy_dir !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_dir: got %h expected 0", enemy_dir);
    end
    do_read(0, 1'b1);
    do_read(3, 1'b0);
    do_read(0, 1'b0);
  endtask

  initial begin
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    ent_x = '0; ent_y = '0; ent_active = '0;
    model_reset();
    test_reset();
    test_snapshot();
    test_dir();
    test_frame_wrap();
`ifdef ENTITY_IRQ_EN
    test_irq();
`endif
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_readdatavalid: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
